mem_request_queue: RTL and testbench

Parametrised successor to the single-entry data request latch in the pipeline's memory stage. Accepts data-memory read/write requests on ihit and holds up to DEPTH of them in order in a FIFO. Presents the oldest request to the dcache and retires it on dhit. Adds registered load-data capture, flush of unissued entries, full/empty status and a back-pressure stall to the hazard unit.

---
 rtl/mem_request_queue.sv | 145 ++++++++++++++
 tb/tb_mem_request_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_request_queue.sv
// In-order FIFO of data-memory requests between the pipeline memory stage and the dcache.
// The head entry is presented from registers. Read completions are captured into rdata.
module mem_request_queue #(
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 2,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dREN_c,
   input  logic              dWEN_c,
   input  logic [ADDR_W-1:0] daddr_c,
   input  logic [DATA_W-1:0] dstore_c,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dload,
   input  logic              flush,
   output logic              dREN_r,
   output logic              dWEN_r,
   output logic [ADDR_W-1:0] daddr_r,
   output logic [DATA_W-1:0] dstore_r,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              stall
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  cnt_fl;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  is_read_q, is_read_d;
   logic [DEPTH-1:0]  is_write_q, is_write_d;
   logic [ADDR_W-1:0] addr_q  [DEPTH];
   logic [DATA_W-1:0] store_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;
   logic              req, accept, deq;
   logic              full_w, empty_w;
   logic              head_valid;

   assign full_w  = (count_q == CNT_W'(DEPTH));
   assign empty_w = (count_q == '0);

   // Dequeue, then flush, then enqueue: the write slot follows the surviving entries.
   always_comb begin
      req    = ihit & (dREN_c | dWEN_c);
      deq    = dhit & ~empty_w;
      head_d = head_q + PTR_W'(deq);
      if (flush) begin
         if (deq) begin
            cnt_fl = '0;
         end else begin
            cnt_fl = (count_q != '0) ? CNT_W'(1) : '0;
         end
      end else begin
         cnt_fl = count_q - CNT_W'(deq);
      end
      wr_ptr  = flush ? (head_d + cnt_fl[PTR_W-1:0]) : tail_q;
      accept  = req & (cnt_fl != CNT_W'(DEPTH));
      count_d = cnt_fl + CNT_W'(accept);
      tail_d  = wr_ptr + PTR_W'(accept);
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic hit_head;
         logic hit_wr;
         assign hit_head = (head_q == PTR_W'(gi));
         assign hit_wr   = accept & (wr_ptr == PTR_W'(gi));
         // A fresh write overrides both the retire of the old head and the flush clear.
         assign valid_d[gi]    = hit_wr | (valid_q[gi] & ~(deq & hit_head) & ~(flush & ~hit_head));
         assign is_read_d[gi]  = hit_wr ? dREN_c : is_read_q[gi];
         assign is_write_d[gi] = hit_wr ? (dWEN_c & ~dREN_c) : is_write_q[gi];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         is_read_q  <= '0;
         is_write_q <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         is_read_q  <= is_read_d;
         is_write_q <= is_write_d;
      end
   end

   // Payload storage needs no reset; head outputs are gated by the valid bit.
   always_ff @(posedge CLK) begin
      if (accept) begin
         addr_q[wr_ptr]  <= daddr_c;
         store_q[wr_ptr] <= dstore_c;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= deq & is_read_q[head_q];
         if (deq & is_read_q[head_q]) begin
            rdata_q <= dload;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         assert (count_q <= CNT_W'(DEPTH));
         assert (count_d <= CNT_W'(DEPTH));
         assert (!(deq && (count_q == '0)));
         assert ((count_q == '0) == (valid_q == '0));
      end
   end

   assign head_valid = valid_q[head_q];
   assign dREN_r     = head_valid & is_read_q[head_q];
   assign dWEN_r     = head_valid & is_write_q[head_q];
   assign daddr_r    = head_valid ? addr_q[head_q]  : '0;
   assign dstore_r   = head_valid ? store_q[head_q] : '0;
   assign rdata      = rdata_q;
   assign rvalid     = rvalid_q;
   assign count      = count_q;
   assign full       = full_w;
   assign empty      = empty_w;
   assign stall      = req & ~accept;

endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue: DEPTH=2 and DEPTH=4 instances checked against a request scoreboard.
module tb_mem_request_queue;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] store;
   } ent_t;

   logic        CLK = 1'b0;
   logic        nrst     [2];
   logic        ihit     [2];
   logic        ren      [2];
   logic        wen      [2];
   logic [31:0] addr_c   [2];
   logic [31:0] store_c  [2];
   logic        dhit     [2];
   logic [31:0] dload    [2];
   logic        flush    [2];
   logic        dren_o   [2];
   logic        dwen_o   [2];
   logic [31:0] daddr_o  [2];
   logic [31:0] dstore_o [2];
   logic [31:0] rdata_o  [2];
   logic        rvalid_o [2];
   logic        full_o   [2];
   logic        empty_o  [2];
   logic        stall_o  [2];
   logic [1:0]  count2;
   logic [2:0]  count4;

   ent_t        sb[$];
   logic [31:0] exp_rdata  [2];
   logic        exp_rvalid [2];
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   mem_request_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) u_dut2 (
      .CLK(CLK), .nRST(nrst[0]), .ihit(ihit[0]), .dREN_c(ren[0]), .dWEN_c(wen[0]),
      .daddr_c(addr_c[0]), .dstore_c(store_c[0]), .dhit(dhit[0]), .dload(dload[0]),
      .flush(flush[0]), .dREN_r(dren_o[0]), .dWEN_r(dwen_o[0]), .daddr_r(daddr_o[0]),
      .dstore_r(dstore_o[0]), .rdata(rdata_o[0]), .rvalid(rvalid_o[0]), .count(count2),
      .full(full_o[0]), .empty(empty_o[0]), .stall(stall_o[0])
   );

   mem_request_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) u_dut4 (
      .CLK(CLK), .nRST(nrst[1]), .ihit(ihit[1]), .dREN_c(ren[1]), .dWEN_c(wen[1]),
      .daddr_c(addr_c[1]), .dstore_c(store_c[1]), .dhit(dhit[1]), .dload(dload[1]),
      .flush(flush[1]), .dREN_r(dren_o[1]), .dWEN_r(dwen_o[1]), .daddr_r(daddr_o[1]),
      .dstore_r(dstore_o[1]), .rdata(rdata_o[1]), .rvalid(rvalid_o[1]), .count(count4),
      .full(full_o[1]), .empty(empty_o[1]), .stall(stall_o[1])
   );

   task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL dut%0d %s observed=%h expected=%h", d, tag, obs, expv);
      end
   endtask

   task automatic check_outs(input int d);
      ent_t        h;
      logic [31:0] cnt;
      int          dep;
      dep = (d == 0) ? 2 : 4;
      cnt = (d == 0) ? {30'd0, count2} : {29'd0, count4};
      if (sb.size() > 0) begin
         h = sb[0];
      end else begin
         h.rd = 1'b0; h.wr = 1'b0; h.addr = '0; h.store = '0;
      end
      chk(d, "dREN_r",   {31'd0, dren_o[d]},   {31'd0, h.rd});
      chk(d, "dWEN_r",   {31'd0, dwen_o[d]},   {31'd0, h.wr});
      chk(d, "daddr_r",  daddr_o[d],           h.addr);
      chk(d, "dstore_r", dstore_o[d],          h.store);
      chk(d, "count",    cnt,                  sb.size());
      chk(d, "empty",    {31'd0, empty_o[d]},  {31'd0, sb.size() == 0});
      chk(d, "full",     {31'd0, full_o[d]},   {31'd0, sb.size() == dep});
      chk(d, "rvalid",   {31'd0, rvalid_o[d]}, {31'd0, exp_rvalid[d]});
      chk(d, "rdata",    rdata_o[d],           exp_rdata[d]);
   endtask

   // One clock of stimulus on DUT d; the scoreboard applies dequeue, flush, enqueue in that order.
   task automatic step(input int d, input logic rst_n, input logic ih, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] s, input logic dh,
                       input logic [31:0] dl, input logic fl, input logic exp_stall);
      ent_t e;
      logic popped;
      nrst[d] = rst_n; ihit[d] = ih; ren[d] = r; wen[d] = w; addr_c[d] = a;
      store_c[d] = s; dhit[d] = dh; dload[d] = dl; flush[d] = fl;
      #1;
      chk(d, "stall", {31'd0, stall_o[d]}, {31'd0, exp_stall});
      @(posedge CLK);
      #1;
      if (!rst_n) begin
         sb.delete();
         exp_rvalid[d] = 1'b0;
         exp_rdata[d]  = '0;
      end else begin
         popped        = 1'b0;
         exp_rvalid[d] = 1'b0;
         if (dh && sb.size() > 0) begin
            e      = sb.pop_front();
            popped = 1'b1;
            if (e.rd) begin
               exp_rvalid[d] = 1'b1;
               exp_rdata[d]  = dl;
            end
         end
         if (fl) begin
            if (popped) sb.delete();
            else while (sb.size() > 1) void'(sb.pop_back());
         end
         if (ih && (r || w) && !exp_stall) begin
            e.rd = r; e.wr = w & ~r; e.addr = a; e.store = s;
            sb.push_back(e);
         end
      end
      $display("dut%0d rst_n=%b ihit=%b ren=%b wen=%b addr=%h dhit=%b flush=%b -> head=%h cnt=%0d rvalid=%b rdata=%h",
               d, rst_n, ih, r, w, a, dh, fl, daddr_o[d], sb.size(), rvalid_o[d], rdata_o[d]);
      check_outs(d);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         nrst[i] = 1'b0; ihit[i] = 1'b0; ren[i] = 1'b0; wen[i] = 1'b0; addr_c[i] = '0;
         store_c[i] = '0; dhit[i] = 1'b0; dload[i] = '0; flush[i] = 1'b0;
         exp_rdata[i] = '0; exp_rvalid[i] = 1'b0;
      end
      repeat (2) @(posedge CLK);
      #1;
      check_outs(0);
      check_outs(1);

      // single read round trip
      step(0, 1, 1, 1, 0, 32'h40, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // fill DEPTH=2, third request stalls, then retire the write
      step(0, 1, 1, 0, 1, 32'h80, 32'h11112222, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 32'h84, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 1, 32'h8C, 32'h33334444, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0, 0, 1, 32'h0BAD0BAD, 0, 0);

      // full queue with same-cycle dhit still accepts
      step(0, 1, 1, 0, 1, 32'h98, 32'h00000005, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 32'h88, 0, 1, 32'h12345678, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0);

      // read takes priority over write; dhit while empty is ignored
      step(0, 1, 1, 1, 1, 32'hA0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 1, 32'h0BADF00D, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 1, 32'h00000055, 0, 0);

      // reset during an outstanding read with dhit asserted
      step(0, 1, 1, 1, 0, 32'hB0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h00000777, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // DEPTH=4 flush behaviour
      step(1, 1, 1, 1, 0, 32'h100, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 1, 32'h104, 32'hAAAA5555, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0, 32'h108, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 1, 1, 1, 0, 32'h90, 0, 1, 32'h31415926, 1, 0);
      step(1, 1, 1, 0, 1, 32'h94, 32'h0000ABCD, 0, 0, 1, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1, 32'h00000099, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1, 32'h00000011, 0, 0);

      // DEPTH=4 fill to full, refused fifth request, then drain with wrap
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 1, i[0], ~i[0], 32'h200 + 32'(i * 4), i[0] ? 32'h0 : 32'(i + 7), 0, 0, 0, 0);
      end
      step(1, 1, 1, 1, 0, 32'h210, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 0, 0, 0, 0, 0, 1, 32'h5000 + 32'(i), 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
